stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: clock `clk`, reset `reset`, where reset is synchronous and active-high.
REQ-002 Parameter DIV, default 10: clk cycles per count tick; legal range 2..65535.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start_stop  input  1  level button; a press event is the cycle where it is 1 and was 0 the previous cycle.
REQ-006 lap  input  1  level button; press event detected as for start_stop.
REQ-007 clear  input  1  level button; press event detected as for start_stop.
REQ-008 count_in  input  32  8-digit BCD value from the downstream decimal counter.
REQ-009 cnt_en  output  1  registered one-cycle pulse; downstream counter increments once per 0->1 transition.
REQ-010 cnt_clr  output  1  registered one-cycle pulse; clears the downstream counter.
REQ-011 display  output  32  BCD value to show: count_in live, or the held lap value.
REQ-012 running  output  1  high in RUN and LAP.
REQ-013 lap_active  output  1  high in LAP.
REQ-014 done  output  1  sticky; set on full-scale stop.

Function
REQ-015 FSM states SHALL be IDLE, RUN, PAUSE and LAP.
REQ-016 Press events SHALL be evaluated with fixed priority: clear > start_stop > lap. At most one event acts per cycle; lower-priority events in the same cycle are discarded.
REQ-017 IDLE: start_stop -> RUN; clear -> stay IDLE and pulse cnt_clr; lap ignored.
REQ-018 RUN: start_stop -> PAUSE; lap -> LAP and load lap_reg with count_in in the same edge; clear ignored.
REQ-019 LAP: lap -> RUN; start_stop -> PAUSE; clear ignored; counting continues.
REQ-020 PAUSE: start_stop -> RUN unless done=1, in which case it is ignored; clear -> IDLE, pulse cnt_clr, clear done; lap ignored.
REQ-021 Prescaler: 16-bit counter 0..DIV-1; increments only in RUN/LAP; holds its value in PAUSE; forced to 0 in IDLE.
REQ-022 Tick: the prescaler is at DIV-1 in RUN/LAP. On a tick the prescaler wraps to 0 and cnt_en is 1 in the following cycle only.
REQ-023 cnt_en SHALL never be high in two consecutive cycles; DIV>=2 guarantees this.
REQ-024 A tick coinciding with a start_stop event that leaves RUN/LAP SHALL NOT produce cnt_en.
REQ-025 Full scale: on a tick with count_in == 32'h99999999, suppress cnt_en, move to PAUSE, and set done=1 the next cycle. done holds until a clear event or reset.
REQ-026 cnt_clr is high in the cycle after an accepted clear event, for exactly one cycle. The prescaler is 0 at that point.
REQ-027 display = lap_reg in LAP, otherwise count_in (combinational mux).
REQ-028 Leaving LAP by start_stop makes display live in PAUSE; lap_reg is retained but not shown.
REQ-029 running and lap_active SHALL be decoded from the registered state.

Reset
REQ-030 On reset the block SHALL set: state IDLE, prescaler 0, lap_reg 0, cnt_en 0, cnt_clr 0, done 0.
REQ-031 On reset the button history registers SHALL load 1, so a button held through reset produces no event.
REQ-032 Reset mid-RUN SHALL abort any pending cnt_en or cnt_clr pulse: both are 0 in the cycle after reset.
REQ-033 Reset SHALL NOT pulse cnt_clr; the downstream counter is reset by its own reset.

Verification (DIV=4, downstream counter model attached)
REQ-034 Run: reset, start_stop press, hold 40 cycles -> cnt_en pulses every 4 cycles, each exactly 1 cycle wide; count_in reaches 0x00000010.
REQ-035 Pause/resume: pause with prescaler=2, wait 20 cycles, resume -> first cnt_en 2 cycles after resume; no cnt_en while paused.
REQ-036 Lap: in RUN at count 0x00000007, lap press -> display holds 0x00000007 while count_in advances; second lap press -> display == count_in next cycle.
REQ-037 Simultaneous: clear+start_stop in PAUSE -> IDLE with a single cnt_clr pulse; start_stop+lap in RUN -> PAUSE with lap_reg unchanged.
REQ-038 Full scale: preload the model to 0x99999999, run -> at the next tick no cnt_en, state PAUSE, done=1; start_stop ignored; clear -> IDLE, done=0, cnt_clr pulse.
REQ-039 Reset mid-operation: assert reset in the cycle cnt_en would rise -> cnt_en stays 0, all outputs at reset values, held buttons produce no event after reset release.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller signal bundle: buttons and downstream count in, counter
// control and display out.
interface stopwatch_ctrl_if;
  logic        start_stop;
  logic        lap;
  logic        clear;
  logic [31:0] count_in;
  logic        cnt_en;
  logic        cnt_clr;
  logic [31:0] display;
  logic        running;
  logic        lap_active;
  logic        done;

  modport master (
    output start_stop, lap, clear, count_in,
    input  cnt_en, cnt_clr, display, running, lap_active, done
  );

  modport slave (
    input  start_stop, lap, clear, count_in,
    output cnt_en, cnt_clr, display, running, lap_active, done
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button edge detection, run/pause/lap FSM and a tick
// prescaler driving an external 8-digit BCD counter.
module stopwatch_ctrl #(
  parameter int unsigned DIV = 10
) (
  input logic           clk,
  input logic           reset,
  stopwatch_ctrl_if.slave sw
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StPause = 2'd2;
  localparam logic [1:0] StLap   = 2'd3;

  localparam logic [15:0] PrescMax  = 16'(DIV - 1);
  localparam logic [31:0] FullScale = 32'h9999_9999;

  logic [1:0]  state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [31:0] lap_reg_q, lap_reg_d;
  logic        cnt_en_q, cnt_en_d;
  logic        cnt_clr_q, cnt_clr_d;
  logic        done_q, done_d;
  logic        ss_hist_q, lap_hist_q, clr_hist_q;

  logic ss_ev, lap_ev, clr_ev;
  logic active, tick, full;

  assign ss_ev  = sw.start_stop & ~ss_hist_q;
  assign lap_ev = sw.lap & ~lap_hist_q;
  assign clr_ev = sw.clear & ~clr_hist_q;

  assign active = (state_q == StRun) || (state_q == StLap);
  assign tick   = active && (presc_q == PrescMax);
  assign full   = tick && (sw.count_in == FullScale);

  // Events a state ignores never block a lower-priority event that it accepts.
  always_comb begin
    state_d   = state_q;
    lap_reg_d = lap_reg_q;
    done_d    = done_q;
    cnt_clr_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_ev) begin
          cnt_clr_d = 1'b1;
        end else if (ss_ev) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (full) begin
          state_d = StPause;
          done_d  = 1'b1;
        end else if (ss_ev) begin
          state_d = StPause;
        end else if (lap_ev) begin
          state_d   = StLap;
          lap_reg_d = sw.count_in;
        end
      end
      StLap: begin
        if (full) begin
          state_d = StPause;
          done_d  = 1'b1;
        end else if (ss_ev) begin
          state_d = StPause;
        end else if (lap_ev) begin
          state_d = StRun;
        end
      end
      StPause: begin
        if (clr_ev) begin
          state_d   = StIdle;
          cnt_clr_d = 1'b1;
          done_d    = 1'b0;
        end else if (ss_ev && !done_q) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Any start_stop event seen while active leaves RUN/LAP, so it kills the tick.
  assign cnt_en_d = tick && !full && !ss_ev;

  always_comb begin
    presc_d = presc_q;
    if (state_d == StIdle) begin
      presc_d = '0;
    end else if (active) begin
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      lap_reg_q  <= '0;
      cnt_en_q   <= 1'b0;
      cnt_clr_q  <= 1'b0;
      done_q     <= 1'b0;
      ss_hist_q  <= 1'b1;
      lap_hist_q <= 1'b1;
      clr_hist_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      lap_reg_q  <= lap_reg_d;
      cnt_en_q   <= cnt_en_d;
      cnt_clr_q  <= cnt_clr_d;
      done_q     <= done_d;
      ss_hist_q  <= sw.start_stop;
      lap_hist_q <= sw.lap;
      clr_hist_q <= sw.clear;
    end
  end

  assign sw.cnt_en     = cnt_en_q;
  assign sw.cnt_clr    = cnt_clr_q;
  assign sw.done       = done_q;
  assign sw.running    = active;
  assign sw.lap_active = (state_q == StLap);
  assign sw.display    = (state_q == StLap) ? lap_reg_q : sw.count_in;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with a BCD downstream counter attached
// and a cycle-level behavioural model of the stopwatch rules.
module tb_stopwatch_ctrl;
  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw_if)
  );

  // Downstream 8-digit BCD counter
  logic [31:0] cnt;
  logic        preload;
  assign sw_if.count_in = cnt;

  function automatic logic [31:0] bcd_inc(input logic [31:0] v);
    logic [31:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset)              cnt <= 32'h0;
    else if (preload)       cnt <= 32'h9999_9999;
    else if (sw_if.cnt_clr) cnt <= 32'h0;
    else if (sw_if.cnt_en)  cnt <= bcd_inc(cnt);
  end

  typedef struct packed {
    logic        en;
    logic        clr;
    logic [31:0] disp;
    logic        run;
    logic        lapa;
    logic        done;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   started = 1'b0;
  int   cyc = 0;

  // Behavioural model
  typedef enum int {Idle, Running, Paused, Lapping} mode_e;
  mode_e       m_mode = Idle;
  int unsigned m_runcyc = 0;  // cycles spent counting since last return to Idle
  logic [31:0] m_lapv = '0;
  bit          m_en = 0, m_clr = 0, m_done = 0;
  bit          h_s = 1, h_l = 1, h_c = 1;
  bit          sv_r = 1, sv_s = 0, sv_l = 0, sv_c = 0;
  logic [31:0] sv_cin = '0;

  task automatic model_step();
    bit    e_s, e_l, e_c, act, tick, full;
    mode_e nxt;
    if (sv_r) begin
      m_mode = Idle; m_runcyc = 0; m_lapv = '0;
      m_en = 0; m_clr = 0; m_done = 0;
      h_s = 1; h_l = 1; h_c = 1;
      return;
    end
    e_s = sv_s && !h_s;
    e_l = sv_l && !h_l;
    e_c = sv_c && !h_c;
    h_s = sv_s; h_l = sv_l; h_c = sv_c;
    act  = (m_mode == Running) || (m_mode == Lapping);
    tick = act && ((m_runcyc % DIV) == DIV - 1);
    full = tick && (sv_cin == 32'h9999_9999);
    m_en  = tick && !full && !e_s;
    m_clr = 0;
    nxt   = m_mode;
    case (m_mode)
      Idle: begin
        if (e_c) m_clr = 1;
        else if (e_s) nxt = Running;
      end
      Running, Lapping: begin
        if (full) begin
          nxt = Paused; m_done = 1;
        end else if (e_s) begin
          nxt = Paused;
        end else if (e_l) begin
          if (m_mode == Running) begin
            nxt = Lapping; m_lapv = sv_cin;
          end else begin
            nxt = Running;
          end
        end
      end
      default: begin
        if (e_c) begin
          nxt = Idle; m_clr = 1; m_done = 0;
        end else if (e_s && !m_done) begin
          nxt = Running;
        end
      end
    endcase
    if (act) m_runcyc++;
    m_mode = nxt;
    if (m_mode == Idle) m_runcyc = 0;
  endtask

  // One clock: advance the model past this edge, drive the next inputs,
  // queue the outputs expected for the new cycle.
  task automatic cycle(input bit r, input bit s, input bit l, input bit c,
                       input bit p = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    reset = r; sw_if.start_stop = s; sw_if.lap = l; sw_if.clear = c; preload = p;
    sv_r = r; sv_s = s; sv_l = l; sv_c = c; sv_cin = cnt;
    e.en   = m_en;
    e.clr  = m_clr;
    e.disp = (m_mode == Lapping) ? m_lapv : cnt;
    e.run  = (m_mode == Running) || (m_mode == Lapping);
    e.lapa = (m_mode == Lapping);
    e.done = m_done;
    q.push_back(e);
    started = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic wait_count(input logic [31:0] target, input int budget);
    int k;
    k = 0;
    while (cnt != target && k < budget) begin
      cycle(0, 0, 0, 0);
      k++;
    end
    if (cnt != target) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_count: count_in=%h required=%h within %0d cycles", cnt, target, budget);
    end
  endtask

  // Monitor
  initial begin
    exp_t e, got;
    forever begin
      @(negedge clk);
      got = {sw_if.cnt_en, sw_if.cnt_clr, sw_if.display, sw_if.running,
             sw_if.lap_active, sw_if.done};
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL outputs cyc %0d: got en=%b clr=%b disp=%h run=%b lap=%b done=%b, required en=%b clr=%b disp=%h run=%b lap=%b done=%b",
                   cyc, got.en, got.clr, got.disp, got.run, got.lapa, got.done,
                   e.en, e.clr, e.disp, e.run, e.lapa, e.done);
        end
      end else if (started) begin
        n_vec++;
        n_bad++;
        $display("FAIL scoreboard: no expectation queued at cyc %0d", cyc);
      end
    end
  end

  initial begin
    int k;
    reset = 1'b1; preload = 1'b0;
    sw_if.start_stop = 1'b0; sw_if.lap = 1'b0; sw_if.clear = 1'b0;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    idle(3);

    // Run
    cycle(0, 1, 0, 0);
    idle(40);

    // Pause, wait, resume
    cycle(0, 1, 0, 0);
    idle(20);
    cycle(0, 1, 0, 0);
    idle(10);

    // Lap at count 7
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 0);
    wait_count(32'h7, 100);
    cycle(0, 0, 1, 0);
    idle(12);
    cycle(0, 0, 1, 0);
    idle(5);

    // Simultaneous presses
    cycle(0, 1, 0, 0);
    idle(3);
    cycle(0, 1, 0, 1);
    idle(3);
    cycle(0, 1, 0, 0);
    idle(6);
    cycle(0, 1, 1, 0);
    idle(4);

    // Full scale
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0);
    idle(8);
    cycle(0, 1, 0, 0);
    idle(4);
    cycle(0, 0, 0, 1);
    idle(3);

    // Reset in the cycle a cnt_en is due, buttons held through reset
    cycle(0, 1, 0, 0);
    k = 0;
    do begin
      cycle(0, 0, 0, 0);
      k++;
    end while (!sw_if.cnt_en && k < 20);
    if (k >= 20) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_cnt_en: cnt_en=%b required=1 within 20 cycles", sw_if.cnt_en);
    end
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 1, 1, 1);
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 1);
    idle(3);

    // Random
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 399) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 149) == 0));
    end
    idle(2);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
